tone_envelope: RTL and testbench

Downstream audio stage for the on-chip tune player. It takes the player's raw square-wave tone and a note gate, and generates a 6-bit attack/decay/sustain/release envelope. It then applies that envelope as a PWM amplitude mask, so the output pin gets a volume-shaped tone instead of a full-scale square wave. It sits between the tune player's tone output and the `io_out` pin mux.

---
 rtl/tone_envelope.sv | 115 +++++++++++
 tb/tb_tone_envelope.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tone_envelope.sv
// ADSR envelope generator driving a PWM amplitude mask over the tune player's square-wave tone.
// The envelope steps at prescaled ticks; the PWM compares a free-running 6-bit counter with the level.
module tone_envelope #(
    parameter int ATTACK_DIV = 4096,
    parameter int DECAY_DIV  = 8192
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       tone_in,
    input  logic       gate,
    input  logic [5:0] peak,
    input  logic [5:0] sustain,
    output logic       pwm_out,
    output logic [5:0] env_level,
    output logic       busy
);
    localparam int MAX_DIV = (ATTACK_DIV > DECAY_DIV) ? ATTACK_DIV : DECAY_DIV;
    localparam int PRESC_W = $clog2(MAX_DIV);
    localparam logic [PRESC_W-1:0] ATTACK_LAST = PRESC_W'(ATTACK_DIV - 1);
    localparam logic [PRESC_W-1:0] DECAY_LAST  = PRESC_W'(DECAY_DIV - 1);

    typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;

    state_t             state;
    logic               gate_d;
    logic [PRESC_W-1:0] presc;
    logic [5:0]         level;
    logic [5:0]         pwm_cnt;
    logic               rise;
    logic               fall;
    logic               tick;

    function automatic logic [5:0] level_up(input logic [5:0] v);
        return (v == 6'd63) ? v : v + 6'd1;
    endfunction

    function automatic logic [5:0] level_dn(input logic [5:0] v);
        return (v == 6'd0) ? v : v - 6'd1;
    endfunction

    assign rise      = gate & ~gate_d;
    assign fall      = ~gate & gate_d;
    assign env_level = level;

    always_comb begin
        tick = 1'b0;
        case (state)
            ATTACK:          tick = (presc == ATTACK_LAST);
            DECAY, RELEASE:  tick = (presc == DECAY_LAST);
            default:         tick = 1'b0;
        endcase
    end

    // Envelope FSM: rise beats fall beats tick; every transition restarts the prescaler.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state  <= IDLE;
            level  <= 6'd0;
            presc  <= '0;
            gate_d <= 1'b0;
            busy   <= 1'b0;
        end else begin
            gate_d <= gate;
            if (rise) begin
                state <= ATTACK;
                presc <= '0;
                busy  <= 1'b1;
            end else if (fall && (state inside {ATTACK, DECAY, SUSTAIN})) begin
                state <= RELEASE;
                presc <= '0;
            end else if (tick) begin
                presc <= '0;
                case (state)
                    ATTACK: begin
                        if (level < peak) begin
                            level <= level_up(level);
                            if (level_up(level) >= peak) state <= DECAY;
                        end else begin
                            state <= DECAY;
                        end
                    end
                    DECAY: begin
                        if (level > sustain) begin
                            level <= level_dn(level);
                            if (level_dn(level) <= sustain) state <= SUSTAIN;
                        end else begin
                            state <= SUSTAIN;
                        end
                    end
                    RELEASE: begin
                        level <= level_dn(level);
                        if (level <= 6'd1) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end else if (state inside {ATTACK, DECAY, RELEASE}) begin
                presc <= presc + 1'b1;
            end
        end
    end

    // PWM mask: the tone passes while the wrapping counter sits below the level.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            pwm_cnt <= 6'd0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 6'd1;
            pwm_out <= tone_in & (pwm_cnt < level);
        end
    end
endmodule

// File: tb/tb_tone_envelope.sv
// Bench for tone_envelope: directed envelope scenarios plus randomized notes against a behavioural model.
module tb_tone_envelope;
    localparam int AD = 4;
    localparam int DD = 8;
    localparam int S_IDLE = 0, S_ATT = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tone_in = 1'b0;
    logic       gate = 1'b0;
    logic [5:0] peak = 6'd8;
    logic [5:0] sustain = 6'd4;
    logic       pwm_out;
    logic [5:0] env_level;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int tone_mode = 0;

    tone_envelope #(.ATTACK_DIV(AD), .DECAY_DIV(DD)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .tone_in  (tone_in),
        .gate     (gate),
        .peak     (peak),
        .sustain  (sustain),
        .pwm_out  (pwm_out),
        .env_level(env_level),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: state kept as plain integers, time in state counted in cycles.
    int m_state = S_IDLE;
    int m_level = 0;
    int m_age = 0;
    int m_pcnt = 0;
    int m_gate_d = 0;
    int m_pwm = 0;

    always @(posedge clk or posedge rst) begin
        int div, ns, nl;
        bit r, f, t;
        if (rst) begin
            m_state <= S_IDLE; m_level <= 0; m_age <= 0;
            m_pcnt <= 0; m_gate_d <= 0; m_pwm <= 0;
        end else begin
            r = gate && (m_gate_d == 0);
            f = !gate && (m_gate_d == 1);
            div = (m_state == S_ATT) ? AD : DD;
            t = (m_state == S_ATT || m_state == S_DEC || m_state == S_REL) && ((m_age + 1) % div == 0);
            ns = m_state;
            nl = m_level;
            if (r) ns = S_ATT;
            else if (f && (m_state == S_ATT || m_state == S_DEC || m_state == S_SUS)) ns = S_REL;
            else if (t) begin
                if (m_state == S_ATT) begin
                    if (nl < int'(peak)) nl++;
                    if (nl >= int'(peak)) ns = S_DEC;
                end else if (m_state == S_DEC) begin
                    if (nl > int'(sustain)) nl--;
                    if (nl <= int'(sustain)) ns = S_SUS;
                end else begin
                    if (nl > 0) nl--;
                    if (nl == 0) ns = S_IDLE;
                end
            end
            m_age    <= (r || ns != m_state) ? 0 : m_age + 1;
            m_state  <= ns;
            m_level  <= nl;
            m_pwm    <= (tone_in && (m_pcnt < m_level)) ? 1 : 0;
            m_pcnt   <= (m_pcnt + 1) % 64;
            m_gate_d <= gate ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("pwm_out", int'(pwm_out), m_pwm);
            chk("env_level", int'(env_level), m_level);
            chk("busy", int'(busy), (m_state != S_IDLE) ? 1 : 0);
        end
    end

    always @(negedge clk) begin
        case (tone_mode)
            0:       tone_in = 1'($urandom);
            1:       tone_in = 1'b1;
            default: tone_in = 1'b0;
        endcase
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_pwm(input string name, input int exp);
        int cnt;
        cnt = 0;
        step(2);
        repeat (64) begin
            step(1);
            cnt += int'(pwm_out);
        end
        chk(name, cnt, exp);
    endtask

    initial begin
        step(2);
        chk("reset_level", int'(env_level), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_pwm", int'(pwm_out), 0);
        rst = 1'b0;
        step(2);

        // Full envelope, gate rises at edge 0
        gate = 1'b1;
        step(1);
        chk("full_busy_e0", int'(busy), 1);
        step(4);  chk("full_e4", int'(env_level), 1);
        step(28); chk("full_e32", int'(env_level), 8);
        step(8);  chk("full_e40", int'(env_level), 7);
        step(24); chk("full_e64", int'(env_level), 4);
        step(35); gate = 1'b0;
        step(25); chk("full_e124", int'(env_level), 1);
        step(8);  chk("full_e132", int'(env_level), 0);
        chk("full_idle", int'(busy), 0);
        step(5);

        // Short note: 10 cycles of gate
        gate = 1'b1;
        step(10); gate = 1'b0;
        step(1);  chk("short_e10", int'(env_level), 2);
        step(16); chk("short_e26", int'(env_level), 0);
        chk("short_idle", int'(busy), 0);
        step(5);

        // Retrigger during release at level 2
        gate = 1'b1;
        step(10); gate = 1'b0;
        step(4);  gate = 1'b1;
        step(1);  chk("retrig_start", int'(env_level), 2);
        step(24); chk("retrig_peak", int'(env_level), 8);
        gate = 1'b0;
        step(80);

        // PWM at level 16
        peak = 6'd16; sustain = 6'd16;
        gate = 1'b1;
        step(90); chk("pwm_level16", int'(env_level), 16);
        tone_mode = 1; count_pwm("pwm_duty16", 16);
        tone_mode = 2; count_pwm("pwm_tone0", 0);
        gate = 1'b0;
        step(140);
        tone_mode = 1; count_pwm("pwm_level0", 0);
        tone_mode = 0;

        // peak = 0
        peak = 6'd0; sustain = 6'd4;
        gate = 1'b1;
        step(5);  chk("peak0_e4", int'(env_level), 0);
        step(16); chk("peak0_busy", int'(busy), 1);
        gate = 1'b0;
        step(12); chk("peak0_idle", int'(busy), 0);

        // sustain above peak
        peak = 6'd8; sustain = 6'd10;
        gate = 1'b1;
        step(60); chk("sus_hold", int'(env_level), 8);
        gate = 1'b0;
        step(80);

        // peak = 63 saturates, then async reset mid-sustain
        peak = 6'd63; sustain = 6'd63;
        gate = 1'b1;
        step(1);
        step(252); chk("peak63", int'(env_level), 63);
        step(20);  chk("peak63_hold", int'(env_level), 63);
        tone_mode = 1;
        step(3);
        #2 rst = 1'b1;
        #1;
        chk("arst_pwm", int'(pwm_out), 0);
        chk("arst_level", int'(env_level), 0);
        chk("arst_busy", int'(busy), 0);
        #1 rst = 1'b0;
        tone_mode = 0;
        step(10);
        gate = 1'b0;
        step(40);

        // Randomized notes with mid-note level changes
        repeat (40) begin
            peak = 6'($urandom_range(0, 12));
            sustain = 6'($urandom_range(0, 12));
            gate = 1'b1;
            step($urandom_range(1, 50));
            if ($urandom_range(0, 1) == 1) sustain = 6'($urandom_range(0, 12));
            step($urandom_range(1, 30));
            gate = 1'b0;
            step($urandom_range(1, 70));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
